// File: rtl/dpc_pkg.sv
// rtl/dpc_pkg.sv - shared constants and types for the DPC window path
package dpc_pkg;
  localparam int DPC_DATA_WIDTH = 16;
  localparam int NEIGH_NUM      = 8;
  localparam int WIN_SIZE       = 5;

  // Same-colour neighbour offsets relative to the window centre, in output order
  localparam int NEIGH_DY [NEIGH_NUM] = '{-2, -2, -2,  0,  0,  2,  2,  2};
  localparam int NEIGH_DX [NEIGH_NUM] = '{-2,  0,  2, -2,  2, -2,  0,  2};

  typedef logic [DPC_DATA_WIDTH-1:0] win_pix_t;
endpackage

// File: rtl/dpc_line_buffer.sv
// rtl/dpc_line_buffer.sv - one line of pixel storage, read-before-write at a shared address
module dpc_line_buffer #(
  parameter int DEPTH      = 1920,
  parameter int DATA_WIDTH = 16,
  localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [AW-1:0]         addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Read sees the old word in the same cycle the new one is written
  assign rdata_o = mem[addr_i];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[addr_i] <= wdata_i;
    end
  end
endmodule

// File: rtl/dpc_window_gen.sv
// rtl/dpc_window_gen.sv - 5x5 Bayer window generator emitting centre plus 8 same-colour neighbours
module dpc_window_gen
  import dpc_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int IMG_WIDTH  = 1920,
  parameter int IMG_HEIGHT = 1080
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic                  in_sof,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_center,
  output logic [DATA_WIDTH-1:0] out_neigh [NEIGH_NUM],
  output logic [15:0]           out_x,
  output logic [15:0]           out_y
);
  localparam int AW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int CTR = WIN_SIZE / 2;
  localparam logic [15:0] LAST_COL = 16'(IMG_WIDTH - 1);
  localparam logic [15:0] LAST_ROW = 16'(IMG_HEIGHT - 1);

  logic [15:0]           col_q, col_d, row_q, row_d;
  logic [15:0]           cur_col, cur_row;
  logic                  emit;
  logic [DATA_WIDTH-1:0] chain [WIN_SIZE];
  logic [DATA_WIDTH-1:0] win_q [WIN_SIZE][WIN_SIZE];
  logic [DATA_WIDTH-1:0] win_d [WIN_SIZE][WIN_SIZE];
  logic [DATA_WIDTH-1:0] neigh_d [NEIGH_NUM];

  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_center_q;
  logic [DATA_WIDTH-1:0] out_neigh_q [NEIGH_NUM];
  logic [15:0]           out_x_q, out_y_q;

  // Start of frame places this pixel at (0,0) regardless of the running counters
  assign cur_col = in_sof ? 16'd0 : col_q;
  assign cur_row = in_sof ? 16'd0 : row_q;
  assign emit    = in_valid && (cur_row >= 16'd4) && (cur_col >= 16'd4);

  assign chain[0] = in_data;

  for (genvar k = 0; k < WIN_SIZE - 1; k++) begin : g_lb
    dpc_line_buffer #(
      .DEPTH      (IMG_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_lb (
      .clk     (clk),
      .we_i    (in_valid),
      .addr_i  (cur_col[AW-1:0]),
      .wdata_i (chain[k]),
      .rdata_o (chain[k+1])
    );
  end

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (in_valid) begin
      if (cur_col == LAST_COL) begin
        col_d = 16'd0;
        row_d = (cur_row == LAST_ROW) ? 16'd0 : cur_row + 16'd1;
      end else begin
        col_d = cur_col + 16'd1;
        row_d = cur_row;
      end
    end
  end

  // Window row 0 is the oldest line, column WIN_SIZE-1 the newest pixel
  always_comb begin
    win_d = win_q;
    if (in_valid) begin
      for (int i = 0; i < WIN_SIZE; i++) begin
        for (int j = 0; j < WIN_SIZE - 1; j++) begin
          win_d[i][j] = win_q[i][j+1];
        end
        win_d[i][WIN_SIZE-1] = chain[WIN_SIZE-1-i];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NEIGH_NUM; k++) begin
      neigh_d[k] = win_d[CTR+NEIGH_DY[k]][CTR+NEIGH_DX[k]];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      col_q        <= 16'd0;
      row_q        <= 16'd0;
      win_q        <= '{default: '0};
      out_valid_q  <= 1'b0;
      out_center_q <= '0;
      out_neigh_q  <= '{default: '0};
      out_x_q      <= 16'd0;
      out_y_q      <= 16'd0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      win_q       <= win_d;
      out_valid_q <= emit;
      if (emit) begin
        out_center_q <= win_d[CTR][CTR];
        out_neigh_q  <= neigh_d;
        out_x_q      <= cur_col - 16'd2;
        out_y_q      <= cur_row - 16'd2;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_center = out_center_q;
  assign out_neigh  = out_neigh_q;
  assign out_x      = out_x_q;
  assign out_y      = out_y_q;
endmodule

// File: tb/tb_dpc_window_gen.sv
// tb/tb_dpc_window_gen.sv - self-checking bench for dpc_window_gen on an 8x6 image
module tb_dpc_window_gen;
  localparam int DW = 16;
  localparam int W  = 8;
  localparam int H  = 6;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_sof = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic [DW-1:0] out_center;
  logic [DW-1:0] out_neigh [8];
  logic [15:0]   out_x, out_y;

  always #5 clk = ~clk;

  dpc_window_gen #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_sof     (in_sof),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_center (out_center),
    .out_neigh  (out_neigh),
    .out_x      (out_x),
    .out_y      (out_y)
  );

  int n_assert = 0;
  int n_fail   = 0;

  localparam int NDY [8] = '{-2, -2, -2, 0, 0, 2, 2, 2};
  localparam int NDX [8] = '{-2, 0, 2, -2, 2, -2, 0, 2};

  int            m_r, m_c, m_wins;
  logic [DW-1:0] pix [H][W];
  logic          e_valid;
  logic [DW-1:0] e_center;
  logic [DW-1:0] e_neigh [8];
  logic [15:0]   e_x, e_y;

  int            dut_wins, first_idx, pix_idx, pulse_viol;
  logic          prev_valid;
  logic [DW-1:0] first_center, last_center;
  logic [DW-1:0] first_neigh [8];
  logic [15:0]   first_x, first_y, last_x, last_y;
  logic [DW-1:0] cen_log [$];
  logic [DW-1:0] n0_log [$];
  bit            chk_en = 1'b0;

  logic [DW-1:0] ramp_first [8] = '{16'h00, 16'h02, 16'h04, 16'h20, 16'h24, 16'h40, 16'h42, 16'h44};

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_assert++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("valid", 32'(out_valid), 32'(e_valid));
      check("center", 32'(out_center), 32'(e_center));
      check("out_x", 32'(out_x), 32'(e_x));
      check("out_y", 32'(out_y), 32'(e_y));
      for (int k = 0; k < 8; k++) begin
        check($sformatf("neigh%0d", k), 32'(out_neigh[k]), 32'(e_neigh[k]));
      end
      if (out_valid) begin
        dut_wins++;
        if (prev_valid) pulse_viol++;
        if (dut_wins == 1) begin
          first_idx    = pix_idx - 1;
          first_center = out_center;
          first_neigh  = out_neigh;
          first_x      = out_x;
          first_y      = out_y;
        end
        last_center = out_center;
        last_x      = out_x;
        last_y      = out_y;
        cen_log.push_back(out_center);
        n0_log.push_back(out_neigh[0]);
      end
      prev_valid = out_valid;
    end
  end

  task automatic clear_stats();
    dut_wins   = 0;
    m_wins     = 0;
    first_idx  = -1;
    pix_idx    = 0;
    pulse_viol = 0;
    prev_valid = 1'b0;
    cen_log.delete();
    n0_log.delete();
  endtask

  task automatic step(input logic v, input logic s, input logic [DW-1:0] d);
    in_valid = v;
    in_sof   = s;
    in_data  = d;
    @(posedge clk);
    #1;
    e_valid = 1'b0;
    if (v) begin
      pix_idx++;
      if (s) begin
        m_r = 0;
        m_c = 0;
      end
      pix[m_r][m_c] = d;
      if (m_r >= 4 && m_c >= 4) begin
        e_valid  = 1'b1;
        e_center = pix[m_r-2][m_c-2];
        for (int k = 0; k < 8; k++) e_neigh[k] = pix[m_r-2+NDY[k]][m_c-2+NDX[k]];
        e_x = 16'(m_c - 2);
        e_y = 16'(m_r - 2);
        m_wins++;
      end
      m_c++;
      if (m_c == W) begin
        m_c = 0;
        m_r = (m_r == H - 1) ? 0 : m_r + 1;
      end
    end
  endtask

  task automatic do_reset(input logic v, input logic [DW-1:0] d);
    reset    = 1'b0;
    in_valid = v;
    in_sof   = 1'b0;
    in_data  = d;
    @(posedge clk);
    #1;
    reset    = 1'b1;
    in_valid = 1'b0;
    e_valid  = 1'b0;
    e_center = '0;
    e_x      = '0;
    e_y      = '0;
    for (int k = 0; k < 8; k++) e_neigh[k] = '0;
    m_r = 0;
    m_c = 0;
  endtask

  task automatic frame(input logic [DW-1:0] base, input bit gaps, input bit konst);
    logic [DW-1:0] d;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        d = konst ? base : base + DW'(y * 16 + x);
        step(1'b1, (y == 0 && x == 0), d);
        if (gaps) step(1'b0, 1'b0, '0);
      end
    end
  endtask

  task automatic partial(input int npix);
    for (int i = 0; i < npix; i++) begin
      step(1'b1, (i == 0), DW'((i / W) * 16 + (i % W)));
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, '0);
  endtask

  initial begin
    do_reset(1'b0, '0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_center", 32'(out_center), 32'd0);
    check("rst_x", 32'(out_x), 32'd0);
    check("rst_y", 32'(out_y), 32'd0);
    chk_en = 1'b1;

    clear_stats();
    frame(16'h0, 1'b0, 1'b0);
    idle(3);
    check("ramp_wins", 32'(dut_wins), 32'd8);
    check("ramp_model_wins", 32'(m_wins), 32'd8);
    check("ramp_first_idx", 32'(first_idx), 32'd36);
    check("ramp_first_center", 32'(first_center), 32'h22);
    check("ramp_first_x", 32'(first_x), 32'd2);
    check("ramp_first_y", 32'(first_y), 32'd2);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("ramp_first_neigh%0d", k), 32'(first_neigh[k]), 32'(ramp_first[k]));
    end
    check("ramp_last_center", 32'(last_center), 32'h35);

    clear_stats();
    frame(16'h0, 1'b1, 1'b0);
    idle(2);
    check("gap_wins", 32'(dut_wins), 32'd8);
    check("gap_pulse", 32'(pulse_viol), 32'd0);
    check("gap_first_center", 32'(first_center), 32'h22);
    check("gap_last_center", 32'(last_center), 32'h35);

    clear_stats();
    frame(16'h0, 1'b0, 1'b0);
    frame(16'h100, 1'b0, 1'b0);
    idle(3);
    check("b2b_wins", 32'(dut_wins), 32'd16);
    if (cen_log.size() >= 9) begin
      check("b2b_second_center", 32'(cen_log[8]), 32'h122);
      check("b2b_second_neigh0", 32'(n0_log[8]), 32'h100);
    end else begin
      check("b2b_second_present", 32'(cen_log.size()), 32'd9);
    end
    check("b2b_last_center", 32'(last_center), 32'h135);

    clear_stats();
    partial(3 * W + 5);
    do_reset(1'b1, 16'h35);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_center", 32'(out_center), 32'd0);
    check("mid_rst_x", 32'(out_x), 32'd0);
    check("mid_rst_y", 32'(out_y), 32'd0);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("mid_rst_neigh%0d", k), 32'(out_neigh[k]), 32'd0);
    end
    clear_stats();
    frame(16'h0, 1'b0, 1'b0);
    idle(3);
    check("post_rst_wins", 32'(dut_wins), 32'd8);
    check("post_rst_first_idx", 32'(first_idx), 32'd36);
    check("post_rst_first_center", 32'(first_center), 32'h22);
    check("post_rst_first_neigh7", 32'(first_neigh[7]), 32'h44);

    clear_stats();
    partial(2 * W + 3);
    check("resync_none_early", 32'(dut_wins), 32'd0);
    clear_stats();
    frame(16'h0, 1'b0, 1'b0);
    idle(3);
    check("resync_wins", 32'(dut_wins), 32'd8);
    check("resync_first_idx", 32'(first_idx), 32'd36);
    check("resync_first_center", 32'(first_center), 32'h22);
    check("resync_first_neigh0", 32'(first_neigh[0]), 32'h00);

    clear_stats();
    frame(16'hFFFF, 1'b0, 1'b1);
    idle(3);
    check("const_wins", 32'(dut_wins), 32'd8);
    check("const_first_center", 32'(first_center), 32'hFFFF);
    check("const_first_neigh0", 32'(first_neigh[0]), 32'hFFFF);
    check("const_first_neigh7", 32'(first_neigh[7]), 32'hFFFF);
    check("const_first_x", 32'(first_x), 32'd2);
    check("const_last_x", 32'(last_x), 32'd5);
    check("const_last_y", 32'(last_y), 32'd3);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
